// File: rtl/axi_outstanding_tracker_pkg.sv
// Shared types and helpers for the AXI outstanding-transaction tracker.
package axi_txn_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  // True when the limit fits the counter and the init value is reachable.
  function automatic bit params_ok(input int width, input int max_out, input int init);
    return (max_out > 0) && (max_out <= (2 ** width) - 1) && (init >= 0) && (init <= max_out);
  endfunction

  function automatic int slice_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/axi_txn_chan_counter.sv
// One saturating outstanding-transaction counter with sticky error flags.
module axi_txn_chan_counter
  import axi_txn_pkg::*;
#(
  parameter int C_WIDTH   = 6,
  parameter int C_MAX_OUT = 32,
  parameter int C_INIT    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [C_WIDTH-1:0] load_value,
  input  logic               incr,
  input  logic               decr,
  input  logic               err_clr,
  output logic [C_WIDTH-1:0] count,
  output logic               is_zero,
  output logic               is_full,
  output logic               ovf_err,
  output logic               unf_err
);

  localparam logic [C_WIDTH-1:0] MAX_V  = C_WIDTH'(C_MAX_OUT);
  localparam logic [C_WIDTH-1:0] INIT_V = C_WIDTH'(C_INIT);

  logic [C_WIDTH-1:0] count_next;
  logic               ovf_set;
  logic               unf_set;

  // Priority: load, then a lone incr or decr; incr together with decr cancels.
  always_comb begin
    count_next = count;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (load) begin
      if (load_value > MAX_V) begin
        count_next = MAX_V;
        ovf_set    = 1'b1;
      end else begin
        count_next = load_value;
      end
    end else if (incr && !decr) begin
      if (count == MAX_V) ovf_set = 1'b1;
      else                count_next = count + C_WIDTH'(1);
    end else if (decr && !incr) begin
      if (count == '0) unf_set = 1'b1;
      else             count_next = count - C_WIDTH'(1);
    end
  end

  // Flags come from count_next so they never lag the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= INIT_V;
      is_zero <= (C_INIT == 0);
      is_full <= (C_INIT == C_MAX_OUT);
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      count   <= count_next;
      is_zero <= (count_next == '0);
      is_full <= (count_next == MAX_V);
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
      unf_err <= unf_set | (unf_err & ~err_clr);
    end
  end

endmodule

// File: rtl/axi_outstanding_tracker.sv
// Multi-channel outstanding-transaction tracker with a global drain state machine.
module axi_outstanding_tracker
  import axi_txn_pkg::*;
#(
  parameter int C_NUM_CH  = 4,
  parameter int C_WIDTH   = 6,
  parameter int C_MAX_OUT = 32,
  parameter int C_INIT    = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [C_NUM_CH-1:0]         load,
  input  logic [C_NUM_CH*C_WIDTH-1:0] load_value,
  input  logic [C_NUM_CH-1:0]         incr,
  input  logic [C_NUM_CH-1:0]         decr,
  input  logic                        err_clr,
  input  logic                        drain_req,
  output logic [C_NUM_CH*C_WIDTH-1:0] count,
  output logic [C_NUM_CH-1:0]         is_zero,
  output logic [C_NUM_CH-1:0]         is_full,
  output logic [C_NUM_CH-1:0]         can_issue,
  output logic                        all_zero,
  output logic                        drain_done,
  output logic [C_NUM_CH-1:0]         ovf_err,
  output logic [C_NUM_CH-1:0]         unf_err,
  output drain_state_t                state
);

  if (!params_ok(C_WIDTH, C_MAX_OUT, C_INIT)) begin : g_bad_params
    $error("axi_outstanding_tracker: C_MAX_OUT/C_INIT out of range for C_WIDTH");
  end

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    axi_txn_chan_counter #(
      .C_WIDTH  (C_WIDTH),
      .C_MAX_OUT(C_MAX_OUT),
      .C_INIT   (C_INIT)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_value(load_value[slice_lo(i, C_WIDTH) +: C_WIDTH]),
      .incr      (incr[i]),
      .decr      (decr[i]),
      .err_clr   (err_clr),
      .count     (count[slice_lo(i, C_WIDTH) +: C_WIDTH]),
      .is_zero   (is_zero[i]),
      .is_full   (is_full[i]),
      .ovf_err   (ovf_err[i]),
      .unf_err   (unf_err[i])
    );
  end

  // is_zero is already derived from the next count, so this AND never lags.
  assign all_zero  = &is_zero;
  assign can_issue = ~is_full & {C_NUM_CH{state == RUN}};

  // A late incr in DONE takes precedence over dropping the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (drain_req) state <= DRAIN;
          drain_done <= 1'b0;
        end
        DRAIN: begin
          if (all_zero && (incr == '0)) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          if (incr != '0) begin
            state      <= DRAIN;
            drain_done <= 1'b0;
          end else if (!drain_req) begin
            state      <= RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_outstanding_tracker.sv
// Scoreboard bench: driver updates a behavioural model and queues expected outputs.
module tb_axi_outstanding_tracker;
  import axi_txn_pkg::*;

  localparam int NCH = 4;
  localparam int WD  = 6;
  localparam int MAXO = 32;
  localparam int W   = NCH * WD + 5 * NCH + 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NCH-1:0]      load = '0;
  logic [NCH*WD-1:0]   load_value = '0;
  logic [NCH-1:0]      incr = '0;
  logic [NCH-1:0]      decr = '0;
  logic                err_clr = 1'b0;
  logic                drain_req = 1'b0;
  logic [NCH*WD-1:0]   count;
  logic [NCH-1:0]      is_zero, is_full, can_issue, ovf_err, unf_err;
  logic                all_zero, drain_done;
  drain_state_t        state;

  axi_outstanding_tracker #(
    .C_NUM_CH(NCH), .C_WIDTH(WD), .C_MAX_OUT(MAXO), .C_INIT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .incr(incr), .decr(decr), .err_clr(err_clr), .drain_req(drain_req),
    .count(count), .is_zero(is_zero), .is_full(is_full), .can_issue(can_issue),
    .all_zero(all_zero), .drain_done(drain_done), .ovf_err(ovf_err),
    .unf_err(unf_err), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers; phase 0=running, 1=draining, 2=drained.
  int m_cnt [NCH];
  bit m_ovf [NCH];
  bit m_unf [NCH];
  int m_phase;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
    m_phase = 0;
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic [NCH*WD-1:0] c;
    logic [NCH-1:0] z, f, ci, o, u;
    bit all0;
    all0 = 1;
    for (int i = 0; i < NCH; i++) begin
      c[i*WD +: WD] = WD'(m_cnt[i]);
      z[i]  = (m_cnt[i] == 0);
      f[i]  = (m_cnt[i] == MAXO);
      ci[i] = (m_cnt[i] != MAXO) && (m_phase == 0);
      o[i]  = m_ovf[i];
      u[i]  = m_unf[i];
      if (m_cnt[i] != 0) all0 = 0;
    end
    return {c, z, f, ci, o, u, all0, (m_phase == 2), 2'(m_phase)};
  endfunction

  function automatic logic [W-1:0] dut_outputs();
    return {count, is_zero, is_full, can_issue, ovf_err, unf_err, all_zero, drain_done, 2'(state)};
  endfunction

  function automatic void model_step(input logic [NCH-1:0] ld, input logic [NCH*WD-1:0] lv,
                                     input logic [NCH-1:0] inc, input logic [NCH-1:0] dec,
                                     input logic clr, input logic dreq);
    bit all0;
    int v;
    all0 = 1;
    for (int i = 0; i < NCH; i++) if (m_cnt[i] != 0) all0 = 0;
    case (m_phase)
      0: if (dreq) m_phase = 1;
      1: if (all0 && inc == '0) m_phase = 2;
      default: if (inc != '0) m_phase = 1; else if (!dreq) m_phase = 0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (clr) begin m_ovf[i] = 0; m_unf[i] = 0; end
      if (ld[i]) begin
        v = int'(lv[i*WD +: WD]);
        if (v > MAXO) begin m_cnt[i] = MAXO; m_ovf[i] = 1; end
        else m_cnt[i] = v;
      end else if (inc[i] && !dec[i]) begin
        if (m_cnt[i] == MAXO) m_ovf[i] = 1; else m_cnt[i]++;
      end else if (dec[i] && !inc[i]) begin
        if (m_cnt[i] == 0) m_unf[i] = 1; else m_cnt[i]--;
      end
    end
  endfunction

  task automatic step(input logic [NCH-1:0] ld, input logic [NCH*WD-1:0] lv,
                      input logic [NCH-1:0] inc, input logic [NCH-1:0] dec,
                      input logic clr, input logic dreq);
    @(negedge clk);
    load = ld; load_value = lv; incr = inc; decr = dec; err_clr = clr; drain_req = dreq;
    model_step(ld, lv, inc, dec, clr, dreq);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input logic dreq);
    step('0, '0, '0, '0, 1'b0, dreq);
  endtask

  task automatic check_now(input string name);
    logic [W-1:0] e, a;
    e = model_outputs();
    a = dut_outputs();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, a, e);
    end
  endtask

  // Monitor: every post-reset edge yields one observable output set.
  always @(posedge clk) begin
    logic [W-1:0] e, a;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_outputs();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, a, e);
      end
    end
  end

  function automatic logic [NCH*WD-1:0] lv_ch(input int ch, input int val);
    logic [NCH*WD-1:0] r;
    r = '0;
    r[ch*WD +: WD] = WD'(val);
    return r;
  endfunction

  initial begin
    logic [NCH-1:0] ld, inc, dec;
    logic [NCH*WD-1:0] lv;
    logic dreq;

    model_reset();
    #12;
    check_now("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Channel 0 fills to the limit, then overflows once, then clears.
    repeat (32) step('0, '0, 4'b0001, '0, 1'b0, 1'b0);
    step('0, '0, 4'b0001, '0, 1'b0, 1'b0);
    step('0, '0, '0, '0, 1'b1, 1'b0);

    // Channel 1 underflow, then cancelling incr+decr at zero.
    step('0, '0, '0, 4'b0010, 1'b0, 1'b0);
    step('0, '0, 4'b0010, 4'b0010, 1'b0, 1'b0);
    step('0, '0, '0, '0, 1'b1, 1'b0);

    // Channel 2 load with a concurrent incr, then an over-limit load.
    step(4'b0100, lv_ch(2, 7), 4'b0100, '0, 1'b0, 1'b0);
    step(4'b0100, lv_ch(2, 40), '0, '0, 1'b0, 1'b0);
    step(4'b0101, '0, '0, '0, 1'b1, 1'b0);

    // Drain with channel 3 outstanding, late issue in DONE, then release.
    repeat (3) step('0, '0, 4'b1000, '0, 1'b0, 1'b0);
    step('0, '0, '0, '0, 1'b0, 1'b1);
    repeat (3) step('0, '0, '0, 4'b1000, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    step('0, '0, 4'b0001, '0, 1'b0, 1'b1);
    step('0, '0, '0, 4'b0001, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // Asynchronous reset while draining with counts outstanding.
    repeat (2) step('0, '0, 4'b0110, '0, 1'b0, 1'b0);
    step('0, '0, '0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    load = '0; incr = '0; decr = '0; err_clr = 1'b0; drain_req = 1'b0;
    model_reset();
    #1;
    check_now("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with drift toward both limits.
    dreq = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) dreq = ~dreq;
      inc = '0; dec = '0; ld = '0; lv = '0;
      for (int i = 0; i < NCH; i++) begin
        if (((n / 100) % 2) == 0) begin
          inc[i] = ($urandom_range(0, 3) != 0);
          dec[i] = ($urandom_range(0, 3) == 0);
        end else begin
          inc[i] = ($urandom_range(0, 3) == 0);
          dec[i] = ($urandom_range(0, 3) != 0);
        end
        if ($urandom_range(0, 31) == 0) begin
          ld[i] = 1'b1;
          lv[i*WD +: WD] = WD'($urandom_range(0, 63));
        end
      end
      step(ld, lv, inc, dec, ($urandom_range(0, 9) == 0), dreq);
    end
    idle(1'b0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_outstanding_tracker.md
Name: axi_outstanding_tracker

Overview:
- Multi-channel outstanding-transaction tracker for the AXI master datapaths; one saturating up/down counter per channel (per AXI ID or per read/write port).
- Generalises the single transaction counter with:
  - a programmable max-outstanding limit and full/can_issue flags;
  - sticky overflow/underflow error flags;
  - a global drain state machine that blocks new issues and signals when every channel has retired.
- Sits between the address-channel issue logic (incr), the response/last-beat logic (decr) and the kernel control FSM (drain).

Parameters:
- C_NUM_CH, 4, number of independent channels.
- C_WIDTH, 6, counter width per channel in bits.
- C_MAX_OUT, 32, max outstanding per channel; elaboration error if C_MAX_OUT > 2**C_WIDTH-1 or C_MAX_OUT == 0.
- C_INIT, 0, reset/initial count of every channel; elaboration error if C_INIT > C_MAX_OUT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load  in  C_NUM_CH  per-channel load strobe.
- load_value  in  C_NUM_CH*C_WIDTH  per-channel load value; channel i uses bits [i*C_WIDTH +: C_WIDTH].
- incr  in  C_NUM_CH  per-channel issue strobe (+1).
- decr  in  C_NUM_CH  per-channel completion strobe (-1).
- err_clr  in  1  clears all sticky error flags.
- drain_req  in  1  level request to drain.
- count  out  C_NUM_CH*C_WIDTH  per-channel count, packed as load_value.
- is_zero  out  C_NUM_CH  count == 0.
- is_full  out  C_NUM_CH  count == C_MAX_OUT.
- can_issue  out  C_NUM_CH  channel may accept a new incr.
- all_zero  out  1  every channel is zero.
- drain_done  out  1  drain complete.
- ovf_err  out  C_NUM_CH  sticky overflow/over-limit error.
- unf_err  out  C_NUM_CH  sticky underflow error.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = C_INIT; is_zero = (C_INIT==0); is_full = (C_INIT==C_MAX_OUT); all_zero = (C_INIT==0).
  - ovf_err = 0, unf_err = 0, drain_done = 0, state = RUN.
- Latency:
  - count, is_zero, is_full, all_zero, errors and state are registered.
  - Inputs sampled at edge t are visible after edge t; is_zero, is_full and all_zero are computed from the next count, never lag count.
- Per-channel priority: load > (incr XOR decr) > hold.
  - incr and decr together: no change, no error, including at 0 and C_MAX_OUT.
- incr alone:
  - count < C_MAX_OUT: +1.
  - count == C_MAX_OUT: hold (saturate) and set ovf_err.
- decr alone:
  - count > 0: -1.
  - count == 0: hold at 0 and set unf_err.
- load:
  - load_value <= C_MAX_OUT: count = load_value.
  - Otherwise: count = C_MAX_OUT and set ovf_err.
  - incr/decr in the load cycle are ignored.
- Errors:
  - err_clr clears ovf_err and unf_err.
  - A set condition in the same cycle as err_clr wins (flag = 1).
- can_issue (combinational from registered state) = ~is_full & (state == RUN).
- all_zero = AND of next is_zero across channels.
- Drain FSM, state type drain_state_t = {RUN, DRAIN, DONE}:
  - RUN -> DRAIN: drain_req == 1.
  - DRAIN -> DONE: registered all_zero == 1 and incr == 0 that cycle.
  - DONE -> RUN: drain_req == 0.
  - DONE -> DRAIN: any incr bit seen in DONE (late issue).
  - drain_done = (state == DONE), registered.
  - In DRAIN/DONE, can_issue = 0, but incr/decr/load are still counted.
  - The drain FSM never alters counts.
- Reset mid-operation: all state returns to the reset values immediately; no pending drain is remembered.

Decomposition:
- Package axi_txn_pkg:
  - drain_state_t enum;
  - localparam function for width checking;
  - helper to compute the per-channel slice offset.
- Sub-module axi_txn_chan_counter: one saturating channel (count, is_zero, is_full, ovf_err, unf_err), parameters C_WIDTH, C_MAX_OUT, C_INIT.
- Top: generate loop of C_NUM_CH channel instances, all_zero reduction, drain FSM.

Test Plan:
- Reset with C_INIT=0 -> all counts 0, is_zero=4'hF, all_zero=1, can_issue=4'hF, errors 0, drain_done=0.
- Channel 0: 32 incr pulses -> count0=32, is_full[0]=1, can_issue[0]=0. Then 33rd incr -> count0 stays 32, ovf_err[0]=1. Then err_clr -> ovf_err[0]=0.
- Channel 1 at 0:
  - decr -> count1=0, unf_err[1]=1.
  - incr+decr together at count1=0 -> count1=0, no new error.
- load channel 2 with 7 together with incr -> count2=7. load 40 -> count2=32, ovf_err[2]=1.
- Channel 3 count=3, drain_req=1:
  - next cycle can_issue=0, state DRAIN.
  - 3 decr -> all_zero=1, then drain_done=1.
  - incr in DONE -> back to DRAIN, drain_done=0.
  - drain_req=0 after re-drain -> RUN.
- Assert rst_n low while counts are nonzero and in DRAIN -> outputs return to reset values without a clock edge.
